// File: rtl/m_stage_dm.sv
// m_stage_dm: memory-stage data memory for the 5-stage MIPS pipeline.
//
// Decodes the load/store opcode of the instruction in M, checks alignment and
// range, merges sub-word stores into a word-organised RAM and returns the
// sign-/zero-extended load result for the MEM/WB register.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high; clears every RAM word
//   M_PC          PC of the instruction in M (store log only)
//   M_Instr       instruction in M, opcode in [31:26]
//   M_ALUAns      effective byte address
//   M_rt_data     forwarded store data
//   M_dm_rdata    extended load result, 0 for non-loads and faulting loads
//   M_byteen      byte-lane write enables for this cycle
//   M_dm_wr       a store commits at the next posedge
//   M_dm_addr_err misaligned or out-of-range load/store
module m_stage_dm #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_Instr,
    input  logic [31:0] M_ALUAns,
    input  logic [31:0] M_rt_data,
    output logic [31:0] M_dm_rdata,
    output logic [3:0]  M_byteen,
    output logic        M_dm_wr,
    output logic        M_dm_addr_err
);

    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpSw  = 6'h2B;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSb  = 6'h28;

    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        lane;

    logic is_load, is_store, is_word, is_half, is_byte, is_signed;
    logic align_err, hi_err, range_err, err;

    logic [31:0] rd_word;
    logic [31:0] wr_data;
    logic [31:0] wr_word_d;
    logic [15:0] rd_half;
    logic [7:0]  rd_byte;

    assign opcode = M_Instr[31:26];
    assign w_idx  = M_ALUAns[ADDR_W+1:2];
    assign lane   = M_ALUAns[1:0];

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_word   = 1'b0;
        is_half   = 1'b0;
        is_byte   = 1'b0;
        is_signed = 1'b0;
        case (opcode)
            OpLw:  begin is_load  = 1'b1; is_word = 1'b1; end
            OpLh:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OpLhu: begin is_load  = 1'b1; is_half = 1'b1; end
            OpLb:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OpLbu: begin is_load  = 1'b1; is_byte = 1'b1; end
            OpSw:  begin is_store = 1'b1; is_word = 1'b1; end
            OpSh:  begin is_store = 1'b1; is_half = 1'b1; end
            OpSb:  begin is_store = 1'b1; is_byte = 1'b1; end
            default: ;
        endcase
    end

    assign align_err = (is_word & (|lane)) | (is_half & lane[0]);
    assign hi_err    = |M_ALUAns[31:ADDR_W+2];
    assign range_err = {1'b0, w_idx} >= DepthLim;
    assign err       = (is_load | is_store) & (align_err | hi_err | range_err);

    // Out-of-range indices never touch the array.
    assign rd_word = range_err ? 32'h0 : mem_q[w_idx];

    always_comb begin
        M_byteen = 4'b0000;
        if (is_store && !err) begin
            if (is_word)      M_byteen = 4'b1111;
            else if (is_half) M_byteen = lane[1] ? 4'b1100 : 4'b0011;
            else              M_byteen = 4'b0001 << lane;
        end
    end

    assign M_dm_wr       = is_store & ~err;
    assign M_dm_addr_err = err;

    // Replicate the store data so every lane carries its byte; byteen picks.
    always_comb begin
        if (is_half)      wr_data = {2{M_rt_data[15:0]}};
        else if (is_byte) wr_data = {4{M_rt_data[7:0]}};
        else              wr_data = M_rt_data;
        for (int i = 0; i < 4; i++) begin
            wr_word_d[8*i +: 8] = M_byteen[i] ? wr_data[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    always_comb begin
        rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte    = rd_word[{lane, 3'b000} +: 8];
        M_dm_rdata = 32'h0;
        if (is_load && !err) begin
            if (is_word)      M_dm_rdata = rd_word;
            else if (is_half) M_dm_rdata = {{16{is_signed & rd_half[15]}}, rd_half};
            else              M_dm_rdata = {{24{is_signed & rd_byte[7]}}, rd_byte};
        end
    end

    // Reset wins over any store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (M_dm_wr) begin
            mem_q[w_idx] <= wr_word_d;
        end
    end

`ifndef SYNTHESIS
    logic [31:0] log_addr;
    assign log_addr = 32'({w_idx, 2'b00});

    always_ff @(posedge clk) begin
        if (!reset && M_dm_wr) begin
            $display("@%h: *%h <= %h", M_PC, log_addr, wr_word_d);
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{M_Instr[25:0], M_PC};

endmodule
